mem_port_arb: RTL

- Arbiter and sequencer for a single-port unified memory shared by the instruction-fetch port and the data-memory stage.
- Grants one requester per issue slot and tracks the fixed memory latency.
- Routes each response back to its owner.
- Generates per-port stall signals for the hazard/PC-write logic; supports discarding an in-flight fetch on a branch flush.

---
 rtl/riscv_arb_pkg.sv | 19 +
 rtl/sat_cnt.sv | 27 ++
 rtl/mem_port_arb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_e : sequencer state (idle, fetch in flight, data access in flight)
//   OWNER_*     : identifies which requester owns the in-flight access
//   CNT_W       : width of the memory latency down-counter
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // Holds WAIT_CYC, whose legal range is 1..15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for arbiter performance statistics.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears the count)
//   i_inc    : increment request for this cycle
//   o_cnt    : current count, sticks at all-ones once reached
module sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arb.sv
// Arbiter/sequencer for a single-port unified memory shared by instruction
// fetch (IF) and the data-memory stage (DM). One access is issued per issue
// slot (idle cycle or the completion cycle of the in-flight access), DM wins
// over IF, and the response is routed back to its owner WAIT_CYC cycles
// after issue. Produces per-port stalls and lets a branch flush drop an
// in-flight fetch response.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   if_req/if_addr         : fetch request (level, held until if_gnt)
//   if_kill                : drop in-flight or same-cycle fetch response
//   if_gnt/if_rvalid/if_rdata/if_stall : fetch handshake, response, stall
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be: data request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata/dm_stall : data handshake, completion, stall
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be : memory command
//   mem_rdata              : memory read data, valid WAIT_CYC cycles after mem_en
//
// Build option: define ARB_PERF_CNT_EN to add perf_conflict_cnt,
// perf_if_wait_cnt and perf_dm_wait_cnt saturating statistics outputs.
module mem_port_arb
    import riscv_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    // Instruction fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    // Data memory port
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [3:0]    dm_be,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    // Memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]   perf_conflict_cnt,
    output logic [31:0]   perf_if_wait_cnt,
    output logic [31:0]   perf_dm_wait_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    if ((WAIT_CYC < 1) || (WAIT_CYC > 15)) begin : g_bad_wait_cyc
        $error("mem_port_arb: WAIT_CYC must be in the range 1..15");
    end

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WAIT_CYC);

    arb_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_kill, w_kill_d;
    logic             r_we, w_we_d;

    logic w_busy;
    logic w_done;
    logic w_slot;
    logic w_issue_dm;
    logic w_issue_if;
    logic w_owner;

    // Slot / issue decode. The completion cycle doubles as an issue slot so
    // that WAIT_CYC=1 sustains one access per cycle.
    always_comb begin
        w_busy     = (r_state != ARB_IDLE);
        w_done     = w_busy && (r_cnt == CNT_W'(1));
        w_slot     = !w_busy || w_done;
        w_issue_dm = w_slot && dm_req;
        w_issue_if = w_slot && !dm_req && if_req;
        w_owner    = (r_state == ARB_BUSY_DM) ? OWNER_DM : OWNER_IF;
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_kill_d  = r_kill;
        w_we_d    = r_we;
        if (w_issue_dm) begin
            w_state_d = ARB_BUSY_DM;
            w_cnt_d   = LOAD_CNT;
            w_kill_d  = 1'b0;
            w_we_d    = dm_we;
        end else if (w_issue_if) begin
            // A kill in the issue cycle targets the old fetch, not this one.
            w_state_d = ARB_BUSY_IF;
            w_cnt_d   = LOAD_CNT;
            w_kill_d  = 1'b0;
            w_we_d    = 1'b0;
        end else if (w_done) begin
            w_state_d = ARB_IDLE;
            w_cnt_d   = '0;
            w_kill_d  = 1'b0;
            w_we_d    = 1'b0;
        end else if (w_busy) begin
            w_cnt_d = r_cnt - CNT_W'(1);
            if ((r_state == ARB_BUSY_IF) && if_kill) begin
                w_kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_kill  <= w_kill_d;
            r_we    <= w_we_d;
        end
    end

    // Output decode. Everything is forced low while rst is high so that the
    // combinational request paths cannot leak a grant during reset.
    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_stall  = 1'b0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        dm_stall  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!rst) begin
            if (w_issue_dm) begin
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                mem_be    = dm_be;
                dm_gnt    = 1'b1;
            end else if (w_issue_if) begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
                mem_be   = 4'hF;
                if_gnt   = 1'b1;
            end

            if (w_done && (w_owner == OWNER_DM)) begin
                dm_rvalid = 1'b1;
                dm_rdata  = r_we ? '0 : mem_rdata;
            end

            // Flushed fetches complete silently, whether the kill came
            // earlier (r_kill) or arrives in the completion cycle itself.
            if (w_done && (w_owner == OWNER_IF) && !r_kill && !if_kill) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end

            if_stall = if_req && !if_rvalid;
            dm_stall = (dm_req && !dm_gnt) || ((w_owner == OWNER_DM) && w_busy && !w_done);
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic w_conflict;

    assign w_conflict = !rst && w_slot && dm_req && if_req;

    sat_cnt #(
        .W(32)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_conflict),
        .o_cnt (perf_conflict_cnt)
    );

    sat_cnt #(
        .W(32)
    ) u_if_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (if_stall),
        .o_cnt (perf_if_wait_cnt)
    );

    sat_cnt #(
        .W(32)
    ) u_dm_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (dm_stall),
        .o_cnt (perf_dm_wait_cnt)
    );
`endif

endmodule
